gcm_plaintext_packer: RTL
=========================

# gcm_plaintext_packer

- Upstream feeder of the N-block GCTR stage.
- Accepts a per-message stream of 128-bit plaintext blocks with a ready/valid handshake and packs them into N_BLOCKS-wide beats.
- Derives the first counter block from the 96-bit IV and drives the GCTR `sop`/`valid` strobes.
- At end of message, builds the GHASH length block `len(A)||len(C)`.

## Interface

Parameters:
- NB_BLOCK, 128, block width in bits
- N_BLOCKS, 2, blocks per output beat
- NB_DATA, N_BLOCKS*NB_BLOCK, output beat width
- NB_IV, 96, IV width (only 96 supported)
- NB_CNT, 32, message block counter width

Ports:
- i_clock  in  1  clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_block  in  NB_BLOCK  plaintext block
- i_block_valid  in  1  block present
- i_block_sop  in  1  first block of message, qualified by valid
- i_block_eop  in  1  last block of message, qualified by valid
- o_block_ready  out  1  block accepted when valid&&ready
- i_iv  in  NB_IV  IV, sampled on the accepted sop block
- o_plaintext_words_x  out  NB_DATA  packed beat, slot 0 in LSBs
- o_initial_counter_block  out  NB_BLOCK  IV||32'h00000002, valid on o_sop
- o_block_mask  out  N_BLOCKS  filled slots of current beat
- o_valid  out  1  beat strobe, one cycle
- o_sop  out  1  first beat of message
- o_eop  out  1  last beat of message
- o_length_block  out  NB_BLOCK  {64'd0, len(C) in bits}
- o_length_valid  out  1  length block strobe, one cycle
- o_drop  out  1  one-cycle pulse, partial message discarded
- o_overflow  out  1  sticky, counter saturated; cleared on next accepted sop

## Operation

- FSM states: IDLE, FILL, LEN.
  - IDLE: blocks without sop are accepted and discarded.
  - IDLE: an accepted sop block latches the IV, clears the slot index and block counter, stores the block in slot 0, and moves to FILL. If eop is also set, the beat is emitted and the FSM moves to LEN.
  - FILL: each accepted block is written to the slot at the slot index, and the index increments.
  - LEN: o_block_ready=0 for exactly one cycle, then return to IDLE.
- Beat emission: a beat is emitted when slot N_BLOCKS-1 is written or an eop block is written.
  - The slot index wraps to 0.
  - Unfilled slots are zero and their o_block_mask bits are 0.
  - An eop beat moves the FSM to LEN.
- o_sop is set only on the first beat after an accepted sop. o_initial_counter_block is J0 = IV||0^31||1 incremented by inc32.
- Block counter:
  - Counts accepted blocks of the current message.
  - Saturates at 2^32-2 and sets o_overflow.
  - len(C) = counter<<7, zero-extended to 64 bits.
  - len(A) = 0 (AAD is handled elsewhere).
- Sop in FILL without a prior eop:
  - The partial beat is discarded and not emitted; o_drop pulses.
  - The new message starts as from IDLE, in the same cycle.
- Reset mid-message: all state and outputs clear asynchronously, and the partial message is lost.

## Timing

- All outputs are registered. Reset values: every output 0, except o_block_ready=1 after reset.
- Latency: the beat appears the cycle after the clock edge that accepts its completing block.
- o_length_valid is asserted the cycle after the o_eop beat. o_length_block holds its value until the next message's length block.
- o_plaintext_words_x, o_initial_counter_block and o_block_mask hold their values between strobes.
- o_block_ready is 1 in IDLE and FILL and 0 in LEN. There is no downstream backpressure: the GCTR stage consumes every o_valid.
- Sustained throughput: one block per cycle, i.e. one beat per N_BLOCKS cycles. The only bubble is the LEN cycle between messages.

## Structure

- Shared package gcm_pkg holds:
  - NB_BLOCK, NB_BYTE
  - the J0 suffix constant 32'h00000001
  - the first-counter suffix 32'h00000002
  - the FSM state encoding
- One sub-module: gcm_slot_buffer, holding the N_BLOCKS slot registers, slot index, mask and emit logic.
- The FSM, IV latch, counter and length block stay in the top level.

## Test plan

- N_BLOCKS=2; 4-block message, IV=96'h0 -> 2 beats, masks 2'b11 and 2'b11. The first beat has o_sop and o_initial_counter_block=128'h2; the second has o_eop. One cycle later, o_length_block=128'h200.
- 3-block message -> beats with mask 11 then 01; slot 1 of the last beat is 0; length block 128'h180.
- Single block with sop&eop together -> one beat with o_sop=o_eop=1 and mask 01; length block 128'h80; ready low for one cycle.
- Sop, then a second sop on the next block -> o_drop pulses and no beat is emitted for the first message. The second message packs normally and o_initial_counter_block uses the second IV.
- Reset asserted while slot 0 holds data -> all outputs 0 immediately. After release, a non-sop block is ignored.
- Counter forced to 2^32-3, then 2 more blocks -> o_overflow=1 and the counter holds at 2^32-2. The next sop clears o_overflow.

Source files
------------

// File: rtl/gcm_pkg.sv
// Shared constants and types for the GCM plaintext packing path.
package gcm_pkg;

   localparam int unsigned NB_BLOCK = 128;
   localparam int unsigned NB_BYTE  = 8;

   // J0 = IV || 0^31 || 1 for a 96-bit IV; the first GCTR counter is inc32(J0).
   localparam logic [31:0] J0_SUFFIX   = 32'h0000_0001;
   localparam logic [31:0] CTR1_SUFFIX = J0_SUFFIX + 32'd1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_LEN  = 2'd2
   } fsm_state_e;

endpackage

// File: rtl/gcm_slot_buffer.sv
// Collects accepted plaintext blocks into N_BLOCKS slots and emits a packed
// beat when the last slot or an end-of-message block is written.
module gcm_slot_buffer #(
   parameter int unsigned NB_BLOCK = 128,
   parameter int unsigned N_BLOCKS = 2
) (
   input  logic                         i_clock,
   input  logic                         i_reset_n,
   input  logic                         i_write,
   input  logic                         i_start,
   input  logic                         i_last,
   input  logic [NB_BLOCK-1:0]          i_block,
   output logic                         o_emit_next,
   output logic                         o_valid,
   output logic [N_BLOCKS*NB_BLOCK-1:0] o_data,
   output logic [N_BLOCKS-1:0]          o_mask
);

   localparam int unsigned       IDX_W    = (N_BLOCKS > 1) ? $clog2(N_BLOCKS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BLOCKS - 1);

   logic [N_BLOCKS-1:0][NB_BLOCK-1:0] slots_q;
   logic [N_BLOCKS-1:0][NB_BLOCK-1:0] slots_d;
   logic [N_BLOCKS-1:0]               mask_q;
   logic [N_BLOCKS-1:0]               mask_d;
   logic [IDX_W-1:0]                  idx_q;
   logic [IDX_W-1:0]                  wr_idx;
   logic                              emit;

   // A start discards whatever partial beat is held, so the new block lands
   // in slot 0 of an otherwise empty beat within the same cycle.
   always_comb begin
      slots_d = i_start ? '0 : slots_q;
      mask_d  = i_start ? '0 : mask_q;
      wr_idx  = i_start ? '0 : idx_q;
      emit    = 1'b0;
      if (i_write) begin
         slots_d[wr_idx] = i_block;
         mask_d[wr_idx]  = 1'b1;
         emit            = i_last || (wr_idx == LAST_IDX);
      end
   end

   assign o_emit_next = emit;

   // Slot storage and registered beat outputs; emitted beats hold until the next emit.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         slots_q <= '0;
         mask_q  <= '0;
         idx_q   <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_mask  <= '0;
      end else begin
         o_valid <= emit;
         if (emit) begin
            o_data  <= slots_d;
            o_mask  <= mask_d;
            slots_q <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
         end else if (i_write) begin
            slots_q <= slots_d;
            mask_q  <= mask_d;
            idx_q   <= wr_idx + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gcm_plaintext_packer.sv
// Upstream feeder of the N-block GCTR stage: packs plaintext blocks into
// beats, supplies the first counter block and the GHASH length block.
module gcm_plaintext_packer #(
   parameter int unsigned NB_BLOCK = gcm_pkg::NB_BLOCK,
   parameter int unsigned N_BLOCKS = 2,
   parameter int unsigned NB_DATA  = N_BLOCKS * NB_BLOCK,
   parameter int unsigned NB_IV    = 96,
   parameter int unsigned NB_CNT   = 32
) (
   input  logic                i_clock,
   input  logic                i_reset_n,
   input  logic [NB_BLOCK-1:0] i_block,
   input  logic                i_block_valid,
   input  logic                i_block_sop,
   input  logic                i_block_eop,
   output logic                o_block_ready,
   input  logic [NB_IV-1:0]    i_iv,
   output logic [NB_DATA-1:0]  o_plaintext_words_x,
   output logic [NB_BLOCK-1:0] o_initial_counter_block,
   output logic [N_BLOCKS-1:0] o_block_mask,
   output logic                o_valid,
   output logic                o_sop,
   output logic                o_eop,
   output logic [NB_BLOCK-1:0] o_length_block,
   output logic                o_length_valid,
   output logic                o_drop,
   output logic                o_overflow
);

   import gcm_pkg::NB_BYTE;
   import gcm_pkg::CTR1_SUFFIX;
   import gcm_pkg::fsm_state_e;
   import gcm_pkg::ST_IDLE;
   import gcm_pkg::ST_FILL;
   import gcm_pkg::ST_LEN;

   // Block count to bit length: bytes per block, then bits per byte.
   localparam int unsigned      LEN_SHIFT = $clog2(NB_BLOCK / NB_BYTE) + $clog2(NB_BYTE);
   localparam logic [NB_CNT-1:0] CNT_MAX  = {{(NB_CNT-1){1'b1}}, 1'b0};

   fsm_state_e        state_q;
   logic [NB_IV-1:0]  iv_q;
   logic [NB_CNT-1:0] cnt_q;
   logic              sop_pend_q;

   logic              accept;
   logic              start;
   logic              write;
   logic              emit;
   logic              first_beat;
   logic [NB_IV-1:0]  iv_now;
   logic [63:0]       len_c;

   assign accept     = i_block_valid && o_block_ready;
   assign start      = accept && i_block_sop;
   assign write      = accept && (i_block_sop || (state_q == ST_FILL));
   assign first_beat = i_block_sop || sop_pend_q;
   assign iv_now     = i_block_sop ? i_iv : iv_q;
   assign len_c      = 64'(cnt_q) << LEN_SHIFT;

   gcm_slot_buffer #(
      .NB_BLOCK (NB_BLOCK),
      .N_BLOCKS (N_BLOCKS)
   ) u_slot_buffer (
      .i_clock     (i_clock),
      .i_reset_n   (i_reset_n),
      .i_write     (write),
      .i_start     (start),
      .i_last      (i_block_eop),
      .i_block     (i_block),
      .o_emit_next (emit),
      .o_valid     (o_valid),
      .o_data      (o_plaintext_words_x),
      .o_mask      (o_block_mask)
   );

   // Message FSM with IV latch, saturating block counter and registered strobes.
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q                 <= ST_IDLE;
         iv_q                    <= '0;
         cnt_q                   <= '0;
         sop_pend_q              <= 1'b0;
         o_block_ready           <= 1'b1;
         o_initial_counter_block <= '0;
         o_sop                   <= 1'b0;
         o_eop                   <= 1'b0;
         o_length_block          <= '0;
         o_length_valid          <= 1'b0;
         o_drop                  <= 1'b0;
         o_overflow              <= 1'b0;
      end else begin
         o_sop          <= 1'b0;
         o_eop          <= 1'b0;
         o_length_valid <= 1'b0;
         o_drop         <= 1'b0;
         case (state_q)
            ST_IDLE, ST_FILL: begin
               // A sop while filling abandons the current message and restarts here.
               if (start) begin
                  iv_q       <= i_iv;
                  cnt_q      <= NB_CNT'(1);
                  o_overflow <= 1'b0;
                  o_drop     <= (state_q == ST_FILL);
               end else if (write) begin
                  if (cnt_q == CNT_MAX) begin
                     o_overflow <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               if (write) begin
                  if (emit) begin
                     o_sop      <= first_beat;
                     o_eop      <= i_block_eop;
                     sop_pend_q <= 1'b0;
                     if (first_beat) begin
                        o_initial_counter_block <= {iv_now, CTR1_SUFFIX};
                     end
                     if (i_block_eop) begin
                        state_q       <= ST_LEN;
                        o_block_ready <= 1'b0;
                     end else begin
                        state_q <= ST_FILL;
                     end
                  end else begin
                     sop_pend_q <= first_beat;
                     state_q    <= ST_FILL;
                  end
               end
            end
            ST_LEN: begin
               o_length_valid <= 1'b1;
               o_length_block <= NB_BLOCK'({64'd0, len_c});
               o_block_ready  <= 1'b1;
               state_q        <= ST_IDLE;
            end
            default: begin
               state_q       <= ST_IDLE;
               o_block_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
